deser32: RTL and testbench
==========================

Name: deser32

Overview:
- Serial-to-parallel converter: samples one bit of `data_in` per clock and assembles fixed-length words (32 bits by default).
- After each complete word, presents it on a registered parallel output and pulses a one-cycle valid strobe.
- Sits at the receive end of a bit-serial link, feeding word-wide downstream logic.
- Framing is implicit: word boundaries are counted from reset release; there is no sync pattern.

Parameters:
- WIDTH, 32, number of serial bits per output word (legal range 2..64).
- MSB_FIRST, 1, 1 = first received bit becomes `data_out[WIDTH-1]`; 0 = first received bit becomes `data_out[0]`.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  1  serial data; sampled on every rising edge of `clk` while not in reset.
- data_out  output  WIDTH  last completely received word; registered.
- data_valid  output  1  one-cycle pulse, high in the cycle after the edge that completed a word.

Behaviour:
- Reset (`rst` high, asynchronous assert):
  - `data_out` = 0, `data_valid` = 0.
  - Internal shift register = 0, bit counter = 0.
  - Inputs are ignored while `rst` is high.
- Reset release: the first rising edge with `rst` low samples bit 0 of word 0.
- Sampling, one bit per rising edge, no gaps, no enable:
  - MSB_FIRST=1: shift register shifts left and `data_in` enters the LSB.
  - MSB_FIRST=0: shift register shifts right and `data_in` enters the MSB.
- Bit counter:
  - Counts 0..WIDTH-1; width is clog2(WIDTH).
  - Wraps to 0 on the edge that samples bit WIDTH-1.
- Word completion, on the edge sampling bit WIDTH-1:
  - `data_out` loads the full word, including the bit sampled on that same edge.
  - `data_valid` goes high for exactly one cycle.
  - Latency: the word is visible immediately after the edge sampling its last bit.
- Between completions:
  - `data_out` holds its value.
  - `data_valid` = 0.
  - Shift register contents are not exposed.
- Back-to-back words:
  - The first bit of word N+1 is sampled on the edge right after word N completes.
  - `data_valid` pulses every WIDTH cycles exactly, never two cycles in a row (WIDTH ≥ 2).
- Reset mid-word: the partial word is discarded, all state is cleared, and counting restarts at bit 0 after release.
- Reset asserted in the same cycle `data_valid` is high: `data_valid` drops immediately (asynchronous clear).
- Input is not synchronised internally; `data_in` must meet setup/hold to `clk`.

Test Plan:
- Reset check: hold `rst` high for 2 cycles while toggling `data_in` -> `data_out` = 0x00000000, `data_valid` = 0 throughout.
- Word 1 after reset release, MSB first, bits 0000 0001 0010 0010 0100 0101 0101 0101 -> after the 32nd edge `data_out` = 0x01224555 and `data_valid` pulses for 1 cycle.
- Back-to-back word 2, bits 1100 1101 1110 1111 1100 1101 1110 1111 -> `data_out` = 0xCDEFCDEF exactly 32 cycles after word 1's pulse; `data_out` holds 0x01224555 until then.
- Back-to-back word 3, bits 1110 1101 1110 0001 1000 0111 1010 1111 -> `data_out` = 0xEDE187AF; 3 total `data_valid` pulses, spaced 32 cycles apart.
- Reset mid-word: send 13 bits of ones, pulse `rst`, then send 32 bits of 0xA5A5A5A5 MSB first -> `data_out` = 0xA5A5A5A5 (no leftover ones), first pulse 32 cycles after release.
- MSB_FIRST=0 instance: send 1 followed by 31 zeros -> `data_out` = 0x00000001; with MSB_FIRST=1 the same stream gives 0x80000000.

Source files
------------

// File: rtl/deser32.sv
// Serial-to-parallel converter: one bit per clock, a registered
// WIDTH-bit word and a one-cycle valid strobe when a word is complete.
module deser32 #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             last;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Next shift value already holds the bit sampled on this edge,
    // so it doubles as the completed word on the last bit.
    always_comb begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], data_in}
                            : {data_in, shift_q[WIDTH-1:1]};
        cnt_d   = last ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            data_valid <= last;
            if (last) begin
                data_out <= shift_d;
            end
        end
    end

endmodule

// File: tb/tb_deser32.sv
// Randomised and directed checks of deser32 against a bit-queue
// reference model for three configurations sharing one serial stream.
module tb_deser32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;

    logic [31:0] d32m;
    logic [31:0] d32l;
    logic [2:0]  d3;
    logic        v32m;
    logic        v32l;
    logic        v3;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    bit q32[$];
    bit q3[$];
    logic [31:0] e32m = '0;
    logic [31:0] e32l = '0;
    logic [2:0]  e3   = '0;
    logic        ev32 = 1'b0;
    logic        ev3  = 1'b0;

    always #5 clk = ~clk;

    deser32 #(.WIDTH(32), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .rst(rst), .data_in(din),
        .data_out(d32m), .data_valid(v32m)
    );

    deser32 #(.WIDTH(32), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .rst(rst), .data_in(din),
        .data_out(d32l), .data_valid(v32l)
    );

    deser32 #(.WIDTH(3), .MSB_FIRST(1'b0)) u_3 (
        .clk(clk), .rst(rst), .data_in(din),
        .data_out(d3), .data_valid(v3)
    );

    always @(posedge clk) begin
        if (v32m) pulses++;
    end

    function automatic logic [63:0] pack(input bit q[$], input int w,
                                         input bit msb);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (msb) r[w-1-i] = q[i];
            else     r[i]     = q[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out32m"}, 64'(d32m), 64'(e32m));
        chk({tag, ".out32l"}, 64'(d32l), 64'(e32l));
        chk({tag, ".out3"},   64'(d3),   64'(e3));
        chk({tag, ".v32m"},   64'(v32m), 64'(ev32));
        chk({tag, ".v32l"},   64'(v32l), 64'(ev32));
        chk({tag, ".v3"},     64'(v3),   64'(ev3));
    endtask

    task automatic clear_model();
        q32.delete();
        q3.delete();
        e32m = '0;
        e32l = '0;
        e3   = '0;
        ev32 = 1'b0;
        ev3  = 1'b0;
    endtask

    // Drive one bit, clock it, then compare against the model.
    task automatic step(input bit b, input string tag);
        din = b;
        @(posedge clk);
        #1;
        if (rst) begin
            clear_model();
        end else begin
            q32.push_back(b);
            q3.push_back(b);
            ev32 = 1'b0;
            ev3  = 1'b0;
            if (q32.size() == 32) begin
                e32m = pack(q32, 32, 1'b1)[31:0];
                e32l = pack(q32, 32, 1'b0)[31:0];
                ev32 = 1'b1;
                q32.delete();
            end
            if (q3.size() == 3) begin
                e3  = pack(q3, 3, 1'b0)[2:0];
                ev3 = 1'b1;
                q3.delete();
            end
        end
        chk_all(tag);
    endtask

    task automatic send_word(input logic [31:0] w, input string tag);
        for (int i = 31; i >= 0; i--) step(w[i], tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk_all({tag, ".async"});
        step(1'b1, {tag, ".hold"});
        step(1'b0, {tag, ".hold"});
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        #1;
        chk_all("reset0");
        step(1'b1, "reset");
        step(1'b0, "reset");
        step(1'b1, "reset");
        rst = 1'b0;

        p0 = pulses;
        send_word(32'h01224555, "w1");
        chk("w1.lit", 64'(d32m), 64'h01224555);
        send_word(32'hCDEFCDEF, "w2");
        chk("w2.lit", 64'(d32m), 64'hCDEFCDEF);
        send_word(32'hEDE187AF, "w3");
        chk("w3.lit", 64'(d32m), 64'hEDE187AF);
        step(1'b0, "w3.after");
        chk("pulses3", 64'(pulses - p0), 64'd3);

        for (int i = 0; i < 13; i++) step(1'b1, "partial");
        do_reset("midrst");
        p0 = pulses;
        for (int i = 0; i < 31; i++) begin
            step(i[0], "a5pre");
        end
        chk("a5.nopulse", 64'(pulses - p0), 64'd0);
        do_reset("realign");
        send_word(32'hA5A5A5A5, "a5");
        chk("a5.lit", 64'(d32m), 64'hA5A5A5A5);
        chk("a5.valid", 64'(v32m), 64'd1);

        send_word(32'h80000000, "imp");
        chk("imp.msb", 64'(d32m), 64'h80000000);
        chk("imp.lsb", 64'(d32l), 64'h00000001);

        do_reset("dvrst");
        send_word(32'h12345678, "pre");
        chk("pre.valid", 64'(v32m), 64'd1);
        rst = 1'b1;
        #1;
        chk("dvrst.drop", 64'(v32m), 64'd0);
        chk("dvrst.out", 64'(d32m), 64'd0);
        clear_model();
        step(1'b1, "dvrst.hold");
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd.rst");
            step(1'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
